// File: rtl/cls381_pkg.sv
// Shared definitions for the colour-sensor sample post-processor.
// Holds the processing FSM state encoding and the output mode encodings.
package cls381_pkg;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_AVG,
    ST_MAX,
    ST_DIV,
    ST_OUT
  } state_e;

  localparam logic MODE_SLICE = 1'b0;
  localparam logic MODE_NORM  = 1'b1;

endpackage

// File: rtl/cls381_restoring_div.sv
// Unsigned serial restoring divider producing one quotient bit per cycle.
// The caller guarantees dividend < divisor * 2**OUT_W, so the upper dividend
// part is already a valid partial remainder and only OUT_W steps are needed.
// done_o is raised during the final iteration cycle and quotient_o already
// includes that cycle's bit, so the result can be captured on the same edge.
module cls381_restoring_div #(
  parameter int OUT_W = 8,
  parameter int AVG_W = 26
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AVG_W+OUT_W-1:0] dividend_i,
  input  logic [AVG_W-1:0]       divisor_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [OUT_W-1:0]       quotient_o
);

  localparam int ITER_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic              busy_q;
  logic [ITER_W-1:0] iter_q;
  logic [AVG_W-1:0]  rem_q;
  logic [OUT_W-1:0]  low_q;
  logic [OUT_W-1:0]  quot_q;
  logic [AVG_W-1:0]  divisor_q;

  logic [AVG_W:0]    trial;
  logic              trialGe;

  // One restoring step: shift in the next dividend bit and try a subtract.
  always_comb begin
    trial   = {rem_q, low_q[OUT_W-1]};
    trialGe = (trial >= {1'b0, divisor_q});
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (iter_q == ITER_W'(OUT_W - 1));
  assign quotient_o = OUT_W'({quot_q, trialGe});

  // Load operands on start, then iterate until the last quotient bit is produced.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      iter_q    <= '0;
      rem_q     <= '0;
      low_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q    <= 1'b1;
      iter_q    <= '0;
      rem_q     <= dividend_i[AVG_W+OUT_W-1:OUT_W];
      low_q     <= dividend_i[OUT_W-1:0];
      quot_q    <= '0;
      divisor_q <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= AVG_W'(trialGe ? (trial - {1'b0, divisor_q}) : trial);
      low_q  <= low_q << 1;
      quot_q <= quotient_o;
      if (done_o) begin
        busy_q <= 1'b0;
      end else begin
        iter_q <= iter_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cls381_sample_proc.sv
// Colour-sensor channel post-processor: block-averages 2**AVG_LOG2 samples
// per channel, then emits either a saturating bit-window slice of the average
// or each channel normalised to the brightest one (full scale = all-ones).
module cls381_sample_proc
  import cls381_pkg::*;
#(
  parameter int CH_NUM   = 3,
  parameter int RAW_W    = 24,
  parameter int OUT_W    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int SH_W     = 5
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_NUM*RAW_W-1:0] in_data,
  input  logic                    clear,
  input  logic                    mode,
  input  logic [SH_W-1:0]         shift_sel,
  output logic                    out_valid,
  output logic [CH_NUM*OUT_W-1:0] out_data,
  output logic [CH_NUM-1:0]       out_sat,
  output logic                    overrun
);

  localparam int AVG_W   = RAW_W + AVG_LOG2;
  localparam int DIV_W   = AVG_W + OUT_W;
  localparam int SAMPLES = 1 << AVG_LOG2;
  localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  state_e                    state_q;
  logic [CNT_W-1:0]          sampleCnt_q;
  logic [AVG_W-1:0]          acc_q [CH_NUM];
  logic [RAW_W-1:0]          avg_q [CH_NUM];
  logic [RAW_W-1:0]          max_q;
  logic                      mode_q;
  logic [SH_W-1:0]           shift_q;
  logic [CH_W-1:0]           ch_q;
  logic [CH_NUM*OUT_W-1:0]   normData_q;
  logic                      outValid_q;
  logic [CH_NUM*OUT_W-1:0]   outData_q;
  logic [CH_NUM-1:0]         outSat_q;
  logic                      overrun_q;

  logic [RAW_W-1:0]          avgNow [CH_NUM];
  logic [CH_NUM*OUT_W-1:0]   sliceData;
  logic [CH_NUM-1:0]         sliceSat;
  logic [RAW_W-1:0]          maxNow;
  logic [CH_NUM*OUT_W-1:0]   normData_d;
  logic                      lastSample;
  logic                      lastChan;

  logic                      divStart;
  logic                      divBusy;
  logic                      divDone;
  logic [OUT_W-1:0]          divQuot;
  logic [DIV_W-1:0]          divDividend;
  logic [AVG_W-1:0]          divDivisor;

  // Window of OUT_W bits starting at s; anything set above the window saturates.
  function automatic logic [OUT_W:0] sliceChan(input logic [RAW_W-1:0] v,
                                               input logic [SH_W-1:0]  s);
    logic [RAW_W+OUT_W-1:0] shifted;
    shifted = {{OUT_W{1'b0}}, v} >> s;
    if (|(shifted >> OUT_W)) begin
      return {1'b1, {OUT_W{1'b1}}};
    end
    return {1'b0, shifted[OUT_W-1:0]};
  endfunction

  assign in_ready   = (state_q == ST_ACC);
  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_sat    = outSat_q;
  assign overrun    = overrun_q;
  assign lastSample = (sampleCnt_q == CNT_W'(SAMPLES - 1));
  assign lastChan   = (ch_q == CH_W'(CH_NUM - 1));

  // Floor average of the finished window plus its slice-mode codes.
  always_comb begin
    sliceData = '0;
    sliceSat  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      avgNow[c] = RAW_W'(acc_q[c] >> AVG_LOG2);
      {sliceSat[c], sliceData[c*OUT_W +: OUT_W]} = sliceChan(avgNow[c], shift_q);
    end
  end

  // Brightest channel of the registered averages, used as the normalisation divisor.
  always_comb begin
    maxNow = avg_q[0];
    for (int c = 1; c < CH_NUM; c++) begin
      if (avg_q[c] > maxNow) begin
        maxNow = avg_q[c];
      end
    end
  end

  // Collect each finished quotient so the visible output only changes with out_valid.
  always_comb begin
    normData_d = normData_q;
    if (divDone) begin
      normData_d[ch_q*OUT_W +: OUT_W] = divQuot;
    end
  end

  // The divider is restarted for each channel as soon as it goes idle in DIV.
  assign divStart    = (state_q == ST_DIV) && !divBusy;
  assign divDividend = (DIV_W'(avg_q[ch_q]) << OUT_W) - DIV_W'(avg_q[ch_q]);
  assign divDivisor  = AVG_W'(max_q);

  cls381_restoring_div #(
    .OUT_W(OUT_W),
    .AVG_W(AVG_W)
  ) u_div (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .start_i   (divStart),
    .dividend_i(divDividend),
    .divisor_i (divDivisor),
    .busy_o    (divBusy),
    .done_o    (divDone),
    .quotient_o(divQuot)
  );

  // Main FSM: accumulate, average, then slice or normalise, with registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_ACC;
      sampleCnt_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
        avg_q[c] <= '0;
      end
      max_q       <= '0;
      mode_q      <= MODE_SLICE;
      shift_q     <= '0;
      ch_q        <= '0;
      normData_q  <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSat_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      if (in_valid && (state_q != ST_ACC)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_ACC: begin
          if (clear) begin
            sampleCnt_q <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
              acc_q[c] <= '0;
            end
          end else if (in_valid) begin
            if (sampleCnt_q == '0) begin
              mode_q  <= mode;
              shift_q <= shift_sel;
            end
            for (int c = 0; c < CH_NUM; c++) begin
              acc_q[c] <= acc_q[c] + AVG_W'(in_data[c*RAW_W +: RAW_W]);
            end
            if (lastSample) begin
              state_q <= ST_AVG;
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        ST_AVG: begin
          avg_q       <= avgNow;
          sampleCnt_q <= '0;
          for (int c = 0; c < CH_NUM; c++) begin
            acc_q[c] <= '0;
          end
          if (mode_q == MODE_NORM) begin
            state_q <= ST_MAX;
          end else begin
            outData_q  <= sliceData;
            outSat_q   <= sliceSat;
            outValid_q <= 1'b1;
            state_q    <= ST_OUT;
          end
        end
        ST_MAX: begin
          max_q <= maxNow;
          ch_q  <= '0;
          if (maxNow == '0) begin
            outData_q  <= '0;
            outSat_q   <= '0;
            outValid_q <= 1'b1;
            state_q    <= ST_OUT;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          normData_q <= normData_d;
          if (divDone) begin
            if (lastChan) begin
              outData_q  <= normData_d;
              outSat_q   <= '0;
              outValid_q <= 1'b1;
              state_q    <= ST_OUT;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end
        ST_OUT: begin
          state_q <= ST_ACC;
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cls381_sample_proc.sv
// Self-checking bench for cls381_sample_proc with a queue of expected results.
module tb_cls381_sample_proc;
  import cls381_pkg::*;

  localparam int CH_NUM   = 3;
  localparam int RAW_W    = 24;
  localparam int OUT_W    = 8;
  localparam int AVG_LOG2 = 2;
  localparam int SH_W     = 5;

  typedef logic [RAW_W-1:0] win_t [4];
  typedef struct {
    logic [CH_NUM*OUT_W-1:0] data;
    logic [CH_NUM-1:0]       sat;
    int                      lat;
  } exp_t;

  logic                    sys_clk;
  logic                    sys_rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_NUM*RAW_W-1:0] in_data;
  logic                    clear;
  logic                    mode;
  logic [SH_W-1:0]         shift_sel;
  logic                    out_valid;
  logic [CH_NUM*OUT_W-1:0] out_data;
  logic [CH_NUM-1:0]       out_sat;
  logic                    overrun;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  cls381_sample_proc #(
    .CH_NUM(CH_NUM), .RAW_W(RAW_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2), .SH_W(SH_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clear    (clear),
    .mode     (mode),
    .shift_sel(shift_sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sat  (out_sat),
    .overrun  (overrun)
  );

  // Free-running clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hard stop in case something goes badly wrong.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present one sample for exactly one clock edge.
  task automatic sendSample(input logic [RAW_W-1:0] r, input logic [RAW_W-1:0] g,
                            input logic [RAW_W-1:0] b);
    in_data  = {b, g, r};
    in_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Push the modelled result, then drive a full window; mode/shift flip after
  // the first sample so only the values captured with it may matter.
  task automatic driveWindow(input logic md, input logic [SH_W-1:0] sh,
                             input win_t r, input win_t g, input win_t b);
    exp_t   e;
    longint sum;
    longint avg [CH_NUM];
    longint mx;
    longint v;
    e.data = '0;
    e.sat  = '0;
    mx     = 0;
    for (int c = 0; c < CH_NUM; c++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        sum += longint'(c == 0 ? r[i] : (c == 1 ? g[i] : b[i]));
      end
      avg[c] = sum / 4;
      if (avg[c] > mx) mx = avg[c];
    end
    if (md == MODE_SLICE) begin
      e.lat = 2;
      for (int c = 0; c < CH_NUM; c++) begin
        v = avg[c] >> sh;
        if (v >= 256) begin
          e.data[c*OUT_W +: OUT_W] = 8'hFF;
          e.sat[c] = 1'b1;
        end else begin
          e.data[c*OUT_W +: OUT_W] = v[7:0];
        end
      end
    end else if (mx == 0) begin
      e.lat = 3;
    end else begin
      e.lat = 3 + CH_NUM * (OUT_W + 1);
      for (int c = 0; c < CH_NUM; c++) begin
        v = (avg[c] * 255) / mx;
        e.data[c*OUT_W +: OUT_W] = v[7:0];
      end
    end
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    mode      = md;
    shift_sel = sh;
    for (int i = 0; i < 4; i++) begin
      sendSample(r[i], g[i], b[i]);
      mode      = ~md;
      shift_sel = ~sh;
    end
  endtask

  // Count cycles after the last sample until out_valid; -1 if it never comes.
  // in_valid is released on negedge number hold (0 = leave it alone).
  task automatic waitForOut(output int lat, input int hold);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge sys_clk);
      if (i == hold) in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    nChecks++; if (out_data !== '0) begin nFails++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    nChecks++; if (out_sat !== '0) begin nFails++; $display("[TB] FAIL reset_out_sat: got %b want 0", out_sat); end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_slice_basic;
    win_t r, g, b;
    exp_t e;
    int   lat;
    r = '{default: 24'h001234};
    g = '{default: 24'h000F00};
    b = '{default: 24'h0000FF};
    driveWindow(MODE_SLICE, 5'd8, r, g, b);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL slice_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL slice_data: got %h want %h", out_data, e.data); end
    nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL slice_sat: got %b want %b", out_sat, e.sat); end
    repeat (3) @(negedge sys_clk);
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL slice_pulse_width: got %b want 0", out_valid); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL slice_hold: got %h want %h", out_data, e.data); end
  endtask

  task automatic test_slice_saturate;
    win_t r, g, b;
    exp_t e;
    int   lat;
    r = '{24'h010000, 24'h010000, 24'h010000, 24'h010004};
    g = '{default: 24'h000F00};
    b = '{default: 24'h0000FF};
    driveWindow(MODE_SLICE, 5'd8, r, g, b);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL sat_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL sat_data: got %h want %h", out_data, e.data); end
    nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL sat_flags: got %b want %b", out_sat, e.sat); end
  endtask

  task automatic test_norm;
    win_t r, g, b;
    exp_t e;
    int   lat;
    r = '{default: 24'd400};
    g = '{default: 24'd200};
    b = '{default: 24'd100};
    driveWindow(MODE_NORM, 5'd0, r, g, b);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL norm_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL norm_data: got %h want %h", out_data, e.data); end
    nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL norm_sat: got %b want %b", out_sat, e.sat); end
  endtask

  task automatic test_norm_zero;
    win_t z;
    exp_t e;
    int   lat;
    z = '{default: 24'd0};
    driveWindow(MODE_NORM, 5'd3, z, z, z);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL zero_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL zero_data: got %h want %h", out_data, e.data); end
    nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL zero_sat: got %b want %b", out_sat, e.sat); end
  endtask

  task automatic test_overrun_clear;
    win_t r, g, b;
    exp_t e;
    int   lat;
    r = '{default: 24'd1000};
    g = '{default: 24'd10};
    b = '{default: 24'd500};
    driveWindow(MODE_NORM, 5'd0, r, g, b);
    in_valid = 1'b1;
    waitForOut(lat, 5);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL ovr_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL ovr_data: got %h want %h", out_data, e.data); end
    nChecks++; if (overrun !== 1'b1) begin nFails++; $display("[TB] FAIL ovr_flag: got %b want 1", overrun); end
    // Two samples, then a clear with a discarded sample, then a full window.
    @(posedge sys_clk);
    #1;
    mode = MODE_SLICE;
    shift_sel = 5'd8;
    sendSample(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    sendSample(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    clear = 1'b1;
    sendSample(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    clear = 1'b0;
    r = '{default: 24'h001234};
    g = '{default: 24'h000F00};
    b = '{default: 24'h0000FF};
    driveWindow(MODE_SLICE, 5'd8, r, g, b);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL clear_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL clear_data: got %h want %h", out_data, e.data); end
    nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL clear_sat: got %b want %b", out_sat, e.sat); end
  endtask

  task automatic test_reset_mid_div;
    win_t r, g, b;
    exp_t e;
    int   lat;
    r = '{default: 24'd400};
    g = '{default: 24'd200};
    b = '{default: 24'd100};
    driveWindow(MODE_NORM, 5'd0, r, g, b);
    repeat (10) @(negedge sys_clk);
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL busy_in_ready: got %b want 0", in_ready); end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    void'(sb.pop_front());
    @(negedge sys_clk);
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rst2_out_valid: got %b want 0", out_valid); end
    nChecks++; if (out_data !== '0) begin nFails++; $display("[TB] FAIL rst2_out_data: got %h want 0", out_data); end
    nChecks++; if (out_sat !== '0) begin nFails++; $display("[TB] FAIL rst2_out_sat: got %b want 0", out_sat); end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("[TB] FAIL rst2_overrun: got %b want 0", overrun); end
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rst2_in_ready: got %b want 1", in_ready); end
    r = '{default: 24'd90};
    g = '{default: 24'd300};
    b = '{default: 24'd150};
    driveWindow(MODE_NORM, 5'd0, r, g, b);
    waitForOut(lat, 0);
    e = sb.pop_front();
    nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL fresh_latency: got %0d want %0d", lat, e.lat); end
    nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL fresh_data: got %h want %h", out_data, e.data); end
  endtask

  task automatic test_random;
    win_t r, g, b;
    exp_t e;
    int   lat;
    logic md;
    logic [SH_W-1:0] sh;
    for (int w = 0; w < 4; w++) begin
      md = 1'($urandom_range(0, 1));
      sh = SH_W'($urandom_range(0, 20));
      for (int i = 0; i < 4; i++) begin
        r[i] = RAW_W'(($urandom() & 32'hFFFFFF) >> $urandom_range(0, 12));
        g[i] = RAW_W'(($urandom() & 32'hFFFFFF) >> $urandom_range(0, 12));
        b[i] = RAW_W'(($urandom() & 32'hFFFFFF) >> $urandom_range(0, 12));
      end
      driveWindow(md, sh, r, g, b);
      waitForOut(lat, 0);
      e = sb.pop_front();
      nChecks++; if (lat !== e.lat) begin nFails++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", w, lat, e.lat); end
      nChecks++; if (out_data !== e.data) begin nFails++; $display("[TB] FAIL rand%0d_data: got %h want %h", w, out_data, e.data); end
      nChecks++; if (out_sat !== e.sat) begin nFails++; $display("[TB] FAIL rand%0d_sat: got %b want %b", w, out_sat, e.sat); end
    end
  endtask

  // Sequence of scenarios followed by the summary.
  initial begin
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    mode      = MODE_SLICE;
    shift_sel = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    test_reset();
    test_slice_basic();
    test_slice_saturate();
    test_norm();
    test_norm_zero();
    test_overrun_clear();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
